// File: rtl/tiny8_encoder.sv
// tiny8_encoder: packs opcode/register/operand fields into 8-bit words, buffers them in a small FIFO and
// streams them to program memory at an auto-incrementing address. Optional macro: TINY8_ENC_WRAP_EN.
module tiny8_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        opcode,
  input  logic [1:0]        rs,
  input  logic [1:0]        rd,
  input  logic [1:0]        delta2,
  input  logic [3:0]        imm4,
  input  logic              use_imm,
  input  logic              base_load,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  output logic              empty,
  output logic              overflow
);

  localparam int IDX_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [7:0]        fifo_q [FIFO_DEPTH];
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              overflow_q, overflow_d;

  logic [7:0] word_s;
  logic       empty_s, full_s, we_s, ready_s, push_s, pop_s, wrap_hit_s;

  always_comb begin
    word_s  = {opcode, rs, (use_imm ? imm4 : {rd, delta2})};
    empty_s = (count_q == {CNT_W{1'b0}});
    full_s  = (count_q == FULL_CNT);
    we_s    = !empty_s && !overflow_q;
    // rst_n gates ready so nothing looks acceptable while reset is held
    ready_s = rst_n && !full_s && !overflow_q && !base_load;
    push_s  = in_valid && ready_s;
    pop_s   = we_s && mem_ack;
`ifdef TINY8_ENC_WRAP_EN
    wrap_hit_s = 1'b0;
`else
    wrap_hit_s = pop_s && (ptr_q == {ADDR_W{1'b1}});
`endif
  end

  always_comb begin
    rd_idx_d   = rd_idx_q;
    wr_idx_d   = wr_idx_q;
    count_d    = count_q;
    ptr_d      = ptr_q;
    overflow_d = overflow_q;
    if (push_s) begin
      wr_idx_d = wr_idx_q + IDX_W'(1);
    end else begin
      wr_idx_d = wr_idx_q;
    end
    if (pop_s) begin
      rd_idx_d = rd_idx_q + IDX_W'(1);
      ptr_d    = ptr_q + ADDR_W'(1);
    end else begin
      rd_idx_d = rd_idx_q;
      ptr_d    = ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // The last address was just written: freeze the pointer and drop everything still buffered
    if (wrap_hit_s) begin
      overflow_d = 1'b1;
      ptr_d      = ptr_q;
      count_d    = {CNT_W{1'b0}};
      rd_idx_d   = {IDX_W{1'b0}};
      wr_idx_d   = {IDX_W{1'b0}};
    end else if (base_load && empty_s) begin
      ptr_d      = base_addr;
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx_q   <= {IDX_W{1'b0}};
      wr_idx_q   <= {IDX_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      ptr_q      <= {ADDR_W{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      rd_idx_q   <= rd_idx_d;
      wr_idx_q   <= wr_idx_d;
      count_q    <= count_d;
      ptr_q      <= ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Word storage needs no reset: it is only read while the count marks the slot as valid
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_q[wr_idx_q] <= word_s;
    end
  end

  always_comb begin
    in_ready  = ready_s;
    mem_we    = we_s;
    mem_addr  = ptr_q;
    mem_wdata = we_s ? fifo_q[rd_idx_q] : 8'h00;
    empty     = empty_s;
    overflow  = overflow_q;
  end

endmodule

// File: tb/tb_tiny8_encoder.sv
// Bench for tiny8_encoder: a table of directed packing vectors, hand-written multi-cycle sequences and
// randomized traffic, all checked cycle by cycle against a queue-based reference model.
module tb_tiny8_encoder;

  localparam int DEPTH = 4;
`ifdef TINY8_ENC_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] opcode = 2'd0, rs = 2'd0, rd = 2'd0, delta2 = 2'd0;
  logic [3:0] imm4 = 4'd0;
  logic       use_imm = 1'b0;
  logic       base_load = 1'b0;
  logic [7:0] base_addr = 8'd0;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_ack = 1'b0;
  logic       empty;
  logic       overflow;

  tiny8_encoder #(.FIFO_DEPTH(DEPTH), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rs(rs), .rd(rd), .delta2(delta2), .imm4(imm4), .use_imm(use_imm),
    .base_load(base_load), .base_addr(base_addr),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .empty(empty), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op, r_s, r_d, d2;
    logic [3:0] imm;
    logic       ui;
    logic [7:0] exp;
  } vec_t;

  vec_t        tbl [6];
  int          vectors = 0;
  int          miscompares = 0;
  bit   [7:0]  mq [$];
  int          mptr = 0;
  bit          movf = 1'b0;
  logic [15:0] wr_log [$];
  logic [7:0]  w [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit [7:0] ref_word();
    int low;
    low = use_imm ? int'(imm4) : int'(rd) * 4 + int'(delta2);
    return 8'(int'(opcode) * 64 + int'(rs) * 16 + low);
  endfunction

  task automatic mreset();
    mq.delete();
    mptr = 0;
    movf = 1'b0;
  endtask

  task automatic set_word(input logic [7:0] wd);
    opcode  = wd[7:6];
    rs      = wd[5:4];
    imm4    = wd[3:0];
    use_imm = 1'b1;
    rd      = 2'($urandom);
    delta2  = 2'($urandom);
  endtask

  // Entered at posedge+1 with inputs set; compares, advances one clock, returns at posedge+1.
  task automatic cycle();
    bit       exp_we, exp_ready, acc, pop, empty_pre;
    bit [7:0] nw;
    #1;
    exp_we    = (mq.size() != 0) && !movf;
    exp_ready = rst_n && (mq.size() < DEPTH) && !movf && !base_load;
    chk("mem_we", 32'(mem_we), 32'(exp_we));
    chk("mem_addr", 32'(mem_addr), 32'(mptr));
    if (exp_we) chk("mem_wdata", 32'(mem_wdata), 32'(mq[0]));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("overflow", 32'(overflow), 32'(movf));
    if (rst_n && mem_we && mem_ack) wr_log.push_back({mem_addr, mem_wdata});
    acc       = in_valid && exp_ready;
    pop       = exp_we && mem_ack;
    empty_pre = (mq.size() == 0);
    nw        = ref_word();
    @(posedge clk);
    if (rst_n) begin
      if (pop) begin
        void'(mq.pop_front());
        if (!WRAP && mptr == 255) begin
          movf = 1'b1;
          mq.delete();
          acc = 1'b0;
        end else begin
          mptr = (mptr + 1) % 256;
        end
      end
      if (acc) mq.push_back(nw);
      if (base_load && empty_pre) begin
        mptr = int'(base_addr);
        movf = 1'b0;
      end
    end
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; in_valid = 1'b0; base_load = 1'b0; mem_ack = 1'b0;
    mreset();
    cycle();
    cycle();
    rst_n = 1'b1;
    wr_log.delete();
  endtask

  initial begin
    tbl[0] = '{2'b10, 2'd1, 2'd2, 2'd3, 4'h0, 1'b0, 8'h9B};
    tbl[1] = '{2'b01, 2'd3, 2'd0, 2'd0, 4'hA, 1'b1, 8'h7A};
    tbl[2] = '{2'b11, 2'd0, 2'd1, 2'd0, 4'h5, 1'b0, 8'hC4};
    tbl[3] = '{2'b00, 2'd2, 2'd3, 2'd3, 4'h5, 1'b1, 8'h25};
    tbl[4] = '{2'b11, 2'd3, 2'd0, 2'd1, 4'hF, 1'b1, 8'hFF};
    tbl[5] = '{2'b00, 2'd0, 2'd0, 2'd0, 4'hF, 1'b0, 8'h00};

    // reset state, with an offer pending
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ready", 32'(in_ready), 32'd0);
    cycle();
    in_valid = 1'b0;
    rst_n = 1'b1;

    // table: pack formats, write one cycle after acceptance, pointer increments
    for (int i = 0; i < 6; i++) begin
      opcode = tbl[i].op; rs = tbl[i].r_s; rd = tbl[i].r_d; delta2 = tbl[i].d2;
      imm4 = tbl[i].imm; use_imm = tbl[i].ui;
      in_valid = 1'b1; mem_ack = 1'b1;
      cycle();
      in_valid = 1'b0;
      chk("tbl_we", 32'(mem_we), 32'd1);
      chk("tbl_wdata", 32'(mem_wdata), 32'(tbl[i].exp));
      chk("tbl_addr", 32'(mem_addr), 32'(i));
      cycle();
    end
    chk("tbl_ptr_end", 32'(mem_addr), 32'd6);

    // backpressure: 5 offers into a 4-deep buffer with no ack
    reset_dut();
    for (int i = 0; i < 5; i++) w[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) begin
      set_word(w[(i < 4) ? i : 4]);
      in_valid = 1'b1;
      cycle();
    end
    chk("bp_ready", 32'(in_ready), 32'd0);
    chk("bp_addr", 32'(mem_addr), 32'd0);
    chk("bp_wdata", 32'(mem_wdata), 32'(w[0]));
    mem_ack = 1'b1;
    cycle();
    chk("bp_ready_after_pop", 32'(in_ready), 32'd1);
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    chk("bp_nwrites", 32'(wr_log.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      chk("bp_write", 32'((wr_log.size() > i) ? wr_log[i] : 16'hDEAD), 32'({8'(i), w[i]}));

    // base_load while empty, then while non-empty
    reset_dut();
    base_load = 1'b1; base_addr = 8'h40;
    cycle();
    base_load = 1'b0;
    set_word(w[1]); in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("bl_addr", 32'(mem_addr), 32'h40);
    base_load = 1'b1; base_addr = 8'h10;
    cycle();
    base_load = 1'b0;
    chk("bl_ignored", 32'(mem_addr), 32'h40);
    mem_ack = 1'b1;
    cycle();
    cycle();
    chk("bl_write", 32'((wr_log.size() > 0) ? wr_log[0] : 16'hDEAD), 32'({8'h40, w[1]}));
    chk("bl_ptr", 32'(mem_addr), 32'h41);

    // address-space boundary
    reset_dut();
    base_load = 1'b1; base_addr = 8'hFF;
    cycle();
    base_load = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_word(w[i]); in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0; mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    chk("bnd_nwrites", 32'(wr_log.size()), WRAP ? 32'd2 : 32'd1);
    chk("bnd_w0", 32'((wr_log.size() > 0) ? wr_log[0] : 16'hDEAD), 32'({8'hFF, w[0]}));
    chk("bnd_ovf", 32'(overflow), 32'(!WRAP));
    chk("bnd_ready", 32'(in_ready), 32'(WRAP));
    chk("bnd_empty", 32'(empty), 32'd1);
    chk("bnd_addr", 32'(mem_addr), WRAP ? 32'h01 : 32'hFF);
    base_load = 1'b1; base_addr = 8'h00;
    cycle();
    base_load = 1'b0;
    chk("bnd_ovf_clr", 32'(overflow), 32'd0);

    // reset in the middle of a stalled stream
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      set_word(w[i]); in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    wr_log.delete();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    mreset();
    mem_ack = 1'b1;
    @(posedge clk); #1;
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    chk("mid_rst_nwrites", 32'(wr_log.size()), 32'd0);

    // randomized traffic against the model
    reset_dut();
    for (int n = 0; n < 600; n++) begin
      in_valid  = 1'($urandom);
      opcode    = 2'($urandom); rs = 2'($urandom); rd = 2'($urandom); delta2 = 2'($urandom);
      imm4      = 4'($urandom); use_imm = 1'($urandom);
      mem_ack   = ($urandom_range(0, 3) != 0);
      base_load = ($urandom_range(0, 19) == 0);
      base_addr = ($urandom_range(0, 1) == 1) ? (8'hFC | 8'($urandom_range(0, 3))) : 8'($urandom);
      cycle();
    end
    base_load = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
